// File: rtl/busca_decod_pkg.sv
// Shared types and constants for the fetch/decode sequencer and its control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: sequencer state encoding, default HALT/JMP/JZ opcodes, 4-bit pc increment helper.
package busca_decod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_DECODE     = 3'd3,
    ST_OPER_WAIT  = 3'd4,
    ST_EXEC       = 3'd5,
    ST_HALT       = 3'd6
  } state_e;

  localparam logic [3:0] DEF_HALT_OP = 4'hF;
  localparam logic [3:0] DEF_JMP_OP  = 4'hE;
  localparam logic [3:0] DEF_JZ_OP   = 4'hD;

  // Program counter wraps modulo 16 with no carry out.
  function automatic logic [3:0] pc_inc(input logic [3:0] pc);
    return pc + 4'd1;
  endfunction

endpackage

// File: rtl/busca_decod_if.sv
// Read port between the sequencer and the 16x8 program/data RAM.
// Latency: mem_rdata reflects mem_addr one clock later (synchronous RAM).
// Backpressure: none; the RAM answers every cycle.
// Signals: mem_addr (sequencer -> RAM, 4b), mem_rdata (RAM -> sequencer, 8b).
interface busca_decod_if;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;

  modport master (output mem_addr, input mem_rdata);
  modport slave  (input mem_addr, output mem_rdata);
endinterface

// File: rtl/contador_pc.sv
// 4-bit program counter with synchronous clear, parallel load and increment.
// Latency: new value visible the cycle after ld/inc.
// Backpressure: none; holds when neither ld nor inc is asserted.
// Ports: clock, clr (sync, active-high), ld/ld_val (load), inc (+1 mod 16), pc (current value).
module contador_pc
  import busca_decod_pkg::*;
(
  input  logic       clock,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  output logic [3:0] pc
);

  logic [3:0] pc_d;
  logic [3:0] pc_q;

  // Load wins over increment.
  always_comb begin
    pc_d = pc_q;
    if (ld) begin
      pc_d = ld_val;
    end else if (inc) begin
      pc_d = pc_inc(pc_q);
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/busca_decod.sv
// Instruction fetch/decode sequencer: fetches mem[pc], resolves HALT/JMP/JZ, fetches operands.
// Latency: 5 cycles per ALU instruction (FETCH..EXEC), 3 cycles per jump.
// Backpressure: run is sampled only in IDLE, at EXEC and at jump DECODE; a started instruction always completes.
// Ports: clock, reset (sync, active-high), run, ram (RAM read port), acc_zero,
//        opcode/operando (held between pulses), exec_valid (1-cycle pulse), pc, halted.
module busca_decod
  import busca_decod_pkg::*;
#(
  parameter logic [3:0] HALT_OP = DEF_HALT_OP,
  parameter logic [3:0] JMP_OP  = DEF_JMP_OP,
  parameter logic [3:0] JZ_OP   = DEF_JZ_OP
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  busca_decod_if.master        ram,
  input  logic                 acc_zero,
  output logic [3:0]           opcode,
  output logic [7:0]           operando,
  output logic                 exec_valid,
  output logic [3:0]           pc,
  output logic                 halted
);

  state_e     state_d, state_q;
  logic [7:0] ir_d, ir_q;
  logic [3:0] opcode_d, opcode_q;
  logic [7:0] operando_d, operando_q;
  logic       pc_ld;
  logic       pc_inc_en;
  logic [3:0] pc_w;

  contador_pc u_pc (
    .clock  (clock),
    .clr    (reset),
    .ld     (pc_ld),
    .ld_val (ir_q[3:0]),
    .inc    (pc_inc_en),
    .pc     (pc_w)
  );

  // DECODE is the only cycle that reads the operand address; all other cycles present pc.
  assign ram.mem_addr = (state_q == ST_DECODE) ? ir_q[3:0] : pc_w;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    opcode_d   = opcode_q;
    operando_d = operando_q;
    pc_ld      = 1'b0;
    pc_inc_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        ir_d    = ram.mem_rdata;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (ir_q[7:4] == HALT_OP) begin
          state_d = ST_HALT;
        end else if (ir_q[7:4] == JMP_OP) begin
          pc_ld   = 1'b1;
          state_d = run ? ST_FETCH : ST_IDLE;
        end else if (ir_q[7:4] == JZ_OP) begin
          pc_ld     = acc_zero;
          pc_inc_en = !acc_zero;
          state_d   = run ? ST_FETCH : ST_IDLE;
        end else begin
          state_d = ST_OPER_WAIT;
        end
      end
      ST_OPER_WAIT: begin
        operando_d = ram.mem_rdata;
        opcode_d   = ir_q[7:4];
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        pc_inc_en = 1'b1;
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        if (!run) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      opcode_q   <= '0;
      operando_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      opcode_q   <= opcode_d;
      operando_q <= operando_d;
    end
  end

  assign opcode     = opcode_q;
  assign operando   = operando_q;
  assign exec_valid = (state_q == ST_EXEC);
  assign halted     = (state_q == ST_HALT);
  assign pc         = pc_w;

endmodule

// File: tb/tb_busca_decod.sv
// Bench for busca_decod: directed and random programs against an instruction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_busca_decod;

  localparam int NMAX = 256;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_JZ   = 4'hD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       acc_zero = 1'b0;
  logic [3:0] opcode;
  logic [7:0] operando;
  logic       exec_valid;
  logic [3:0] pc;
  logic       halted;

  busca_decod_if bus ();

  busca_decod dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .ram        (bus),
    .acc_zero   (acc_zero),
    .opcode     (opcode),
    .operando   (operando),
    .exec_valid (exec_valid),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [16];
  always @(posedge clock) bus.mem_rdata <= mem[bus.mem_addr];

  // Per-cycle stimulus plan.
  bit run_a [NMAX];
  bit rst_a [NMAX];
  bit acc_a [NMAX];

  // Expected outputs per cycle.
  bit         e_vld  [NMAX];
  logic [3:0] e_addr [NMAX];
  bit         e_ev   [NMAX];
  bit         e_halt [NMAX];
  logic [3:0] e_pc   [NMAX];
  logic [3:0] e_opc  [NMAX];
  logic [7:0] e_opd  [NMAX];

  // Observed outputs per cycle.
  logic [3:0] d_addr [NMAX];
  logic       d_ev   [NMAX];
  logic       d_halt [NMAX];
  logic [3:0] d_pc   [NMAX];
  logic [3:0] d_opc  [NMAX];
  logic [7:0] d_opd  [NMAX];

  int vectors = 0;
  int miscompares = 0;
  int cur_t = 0;
  bit chk_en = 1'b0;

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return 4'((int'(v) + 1) % 16);
  endfunction

  function automatic void put(input int t, input logic [3:0] addr, input bit ev, input bit h,
                              input logic [3:0] p, input logic [3:0] oc, input logic [7:0] od);
    e_vld[t]  = 1'b1;
    e_addr[t] = addr;
    e_ev[t]   = ev;
    e_halt[t] = h;
    e_pc[t]   = p;
    e_opc[t]  = oc;
    e_opd[t]  = od;
  endfunction

  // Instruction-level model: walks the program one instruction at a time, laying down
  // the expected output of every cycle the instruction occupies. Cycle 0 is always reset.
  task automatic build_model(input int n);
    logic [3:0] p, oc, op, a;
    logic [7:0] od, ins;
    bit fetch_now, stop;
    int t, len, last;
    for (int i = 0; i < NMAX; i++) e_vld[i] = 1'b0;
    p = 4'h0; oc = 4'h0; od = 8'h00; fetch_now = 1'b0; t = 1;
    while (t < n) begin
      if (!fetch_now) begin
        put(t, p, 1'b0, 1'b0, p, oc, od);
        if (rst_a[t]) begin
          p = 4'h0; oc = 4'h0; od = 8'h00;
        end else if (run_a[t]) begin
          fetch_now = 1'b1;
        end
        t++;
        continue;
      end
      ins = mem[p];
      op  = ins[7:4];
      a   = ins[3:0];
      len = (op == OP_HALT || op == OP_JMP || op == OP_JZ) ? 3 : 5;
      stop = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (t + k >= n) begin
          stop = 1'b1; t = n; break;
        end
        if (k == 4) begin
          oc = op; od = mem[a];
        end
        put(t + k, (k == 2) ? a : p, (k == 4), 1'b0, p, oc, od);
        if (rst_a[t + k]) begin
          p = 4'h0; oc = 4'h0; od = 8'h00; fetch_now = 1'b0;
          stop = 1'b1; t = t + k + 1; break;
        end
      end
      if (stop) continue;
      last = t + len - 1;
      t    = t + len;
      if (op == OP_HALT) begin
        fetch_now = 1'b0;
        while (t < n) begin
          put(t, p, 1'b0, 1'b1, p, oc, od);
          t++;
          if (rst_a[t-1]) begin
            p = 4'h0; oc = 4'h0; od = 8'h00; break;
          end
          if (!run_a[t-1]) break;
        end
      end else if (op == OP_JMP) begin
        p = a; fetch_now = run_a[last];
      end else if (op == OP_JZ) begin
        p = acc_a[last] ? a : inc4(p); fetch_now = run_a[last];
      end else begin
        p = inc4(p); fetch_now = run_a[last];
      end
    end
  endtask

  function automatic void cmp(input string name, input int t, input logic [7:0] got, input logic [7:0] want);
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, t, got, want);
    end
  endfunction

  // Single compare process: every checked cycle against the model.
  always @(negedge clock) begin
    if (chk_en && cur_t >= 1) begin
      d_addr[cur_t] = bus.mem_addr;
      d_ev[cur_t]   = exec_valid;
      d_halt[cur_t] = halted;
      d_pc[cur_t]   = pc;
      d_opc[cur_t]  = opcode;
      d_opd[cur_t]  = operando;
      if (e_vld[cur_t]) begin
        vectors++;
        cmp("mem_addr",   cur_t, {4'h0, bus.mem_addr}, {4'h0, e_addr[cur_t]});
        cmp("exec_valid", cur_t, {7'h0, exec_valid},   {7'h0, e_ev[cur_t]});
        cmp("halted",     cur_t, {7'h0, halted},       {7'h0, e_halt[cur_t]});
        cmp("pc",         cur_t, {4'h0, pc},           {4'h0, e_pc[cur_t]});
        cmp("opcode",     cur_t, {4'h0, opcode},       {4'h0, e_opc[cur_t]});
        cmp("operando",   cur_t, operando,             e_opd[cur_t]);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic int count_ev(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (d_ev[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin
      run_a[i] = 1'b0; rst_a[i] = 1'b0; acc_a[i] = 1'b0;
    end
    rst_a[0] = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic run_scenario(input int n);
    build_model(n);
    for (int t = 0; t < n; t++) begin
      @(posedge clock);
      #1;
      reset    = rst_a[t];
      run      = run_a[t];
      acc_zero = acc_a[t];
      cur_t    = t;
      chk_en   = 1'b1;
    end
    @(posedge clock);
    #1;
    chk_en = 1'b0;
    run    = 1'b0;
  endtask

  initial begin
    // ALU instruction straight out of reset.
    clear_stim();
    mem[0] = 8'h15; mem[5] = 8'h2A;
    for (int i = 1; i < 20; i++) run_a[i] = 1'b1;
    run_scenario(20);
    lit("rst_pc",       {4'h0, d_pc[1]},  8'h00);
    lit("rst_halted",   {7'h0, d_halt[1]}, 8'h00);
    lit("rst_opcode",   {4'h0, d_opc[1]}, 8'h00);
    lit("first_fetch",  {4'h0, d_addr[2]}, 8'h00);
    lit("alu_no_early", {7'h0, d_ev[5]},  8'h00);
    lit("alu_ev",       {7'h0, d_ev[6]},  8'h01);
    lit("alu_opcode",   {4'h0, d_opc[6]}, 8'h01);
    lit("alu_operando", d_opd[6],         8'h2A);
    lit("alu_pc_after", {4'h0, d_pc[7]},  8'h01);

    // JMP 9 then HALT; leave HALT by dropping run.
    clear_stim();
    mem[0] = 8'hE9; mem[9] = 8'hF0;
    for (int i = 1; i < 12; i++) run_a[i] = 1'b1;
    run_scenario(20);
    lit("jmp_pc",        {4'h0, d_pc[5]},  8'h09);
    lit("halt_not_yet",  {7'h0, d_halt[7]}, 8'h00);
    lit("halt_set",      {7'h0, d_halt[8]}, 8'h01);
    lit("halt_no_ev",    8'(count_ev(1, 19)), 8'h00);
    lit("halt_exit",     {7'h0, d_halt[13]}, 8'h00);
    lit("halt_pc_kept",  {4'h0, d_pc[13]}, 8'h09);

    // JZ taken and not taken.
    clear_stim();
    mem[0] = 8'hD7;
    for (int i = 1; i < 20; i++) begin run_a[i] = 1'b1; acc_a[i] = 1'b1; end
    run_scenario(20);
    lit("jz_taken_pc", {4'h0, d_pc[5]}, 8'h07);
    clear_stim();
    mem[0] = 8'hD7;
    for (int i = 1; i < 20; i++) run_a[i] = 1'b1;
    run_scenario(20);
    lit("jz_not_taken_pc", {4'h0, d_pc[5]}, 8'h01);

    // ALU at pc=F wraps to 0.
    clear_stim();
    mem[0] = 8'hEF; mem[15] = 8'h13; mem[3] = 8'h55;
    for (int i = 1; i < 20; i++) run_a[i] = 1'b1;
    run_scenario(20);
    lit("wrap_ev",       {7'h0, d_ev[9]},   8'h01);
    lit("wrap_operando", d_opd[9],          8'h55);
    lit("wrap_pc",       {4'h0, d_pc[10]},  8'h00);
    lit("wrap_fetch",    {4'h0, d_addr[10]}, 8'h00);

    // run dropped during FETCH_WAIT, then resumed.
    clear_stim();
    mem[0] = 8'h15; mem[5] = 8'h2A;
    run_a[1] = 1'b1; run_a[2] = 1'b1;
    for (int i = 10; i < 20; i++) run_a[i] = 1'b1;
    run_scenario(20);
    lit("drop_ev_count", 8'(count_ev(1, 10)), 8'h01);
    lit("drop_ev",       {7'h0, d_ev[6]},   8'h01);
    lit("drop_idle_pc",  {4'h0, d_pc[8]},   8'h01);
    lit("resume_fetch",  {4'h0, d_addr[11]}, 8'h01);

    // Reset asserted in OPER_WAIT of the second instruction.
    clear_stim();
    mem[0] = 8'h15; mem[5] = 8'h2A; mem[1] = 8'h32; mem[2] = 8'h77;
    for (int i = 1; i < 20; i++) run_a[i] = 1'b1;
    rst_a[10] = 1'b1;
    run_scenario(20);
    lit("pre_rst_opcode",   {4'h0, d_opc[10]}, 8'h01);
    lit("pre_rst_operando", d_opd[10],         8'h2A);
    lit("rst_ow_ev",        {7'h0, d_ev[11]},  8'h00);
    lit("rst_ow_opcode",    {4'h0, d_opc[11]}, 8'h00);
    lit("rst_ow_operando",  d_opd[11],         8'h00);
    lit("rst_ow_pc",        {4'h0, d_pc[11]},  8'h00);
    lit("rst_ow_refetch",   {4'h0, d_addr[12]}, 8'h00);

    // Random programs, run, acc_zero and occasional reset.
    for (int s = 0; s < 6; s++) begin
      clear_stim();
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      for (int i = 1; i < 200; i++) begin
        run_a[i] = ($urandom_range(0, 7) != 0);
        acc_a[i] = 1'($urandom_range(0, 1));
        rst_a[i] = ($urandom_range(0, 49) == 0);
      end
      run_scenario(200);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/busca_decod.md
BUSCA_DECOD -- requirements
Module: busca_decod

Interface
REQ-001 SHALL have parameter HALT_OP, default 4'hF: opcode that stops sequencing.
REQ-002 SHALL have parameter JMP_OP, default 4'hE: unconditional jump opcode.
REQ-003 SHALL have parameter JZ_OP, default 4'hD: jump-if-accumulator-zero opcode.
REQ-004 SHALL use one clock and synchronous active-high reset; clock and reset are listed first.
REQ-005 SHALL have port clock, input, 1 bit: system clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port run, input, 1 bit: enable sequencing.
REQ-008 SHALL have port mem_addr, output, 4 bits: address to the 16x8 program/data RAM.
REQ-009 SHALL have port mem_rdata, input, 8 bits: RAM read data, valid one cycle after mem_addr.
REQ-010 SHALL have port acc_zero, input, 1 bit: accumulator-equals-zero flag from the register stage.
REQ-011 SHALL have port opcode, output, 4 bits: decoded opcode to the control unit/ULA.
REQ-012 SHALL have port operando, output, 8 bits: operand fetched from mem[instruction[3:0]].
REQ-013 SHALL have port exec_valid, output, 1 bit: one-cycle pulse; opcode and operando valid.
REQ-014 SHALL have port pc, output, 4 bits: current program counter.
REQ-015 SHALL have port halted, output, 1 bit: high while in HALT.

Function
REQ-016 SHALL implement states IDLE, FETCH, FETCH_WAIT, DECODE, OPER_WAIT, EXEC, HALT.
REQ-017 SHALL drive mem_addr = ir[3:0] in DECODE, otherwise pc (combinational from state).
REQ-018 IDLE: run=1 -> FETCH; run=0 -> stay; pc unchanged.
REQ-019 FETCH -> FETCH_WAIT unconditionally (RAM read launched at pc).
REQ-020 FETCH_WAIT: latch mem_rdata into instruction register ir; -> DECODE.
REQ-021 DECODE, ir[7:4]=HALT_OP: -> HALT, pc unchanged.
REQ-022 DECODE, ir[7:4]=JMP_OP: pc <= ir[3:0]; -> FETCH if run=1, else IDLE.
REQ-023 DECODE, ir[7:4]=JZ_OP: pc <= acc_zero ? ir[3:0] : pc+1; -> FETCH if run=1, else IDLE.
REQ-024 DECODE, other opcodes: launch operand read at ir[3:0]; -> OPER_WAIT.
REQ-025 OPER_WAIT: latch mem_rdata into operando, ir[7:4] into opcode; -> EXEC.
REQ-026 EXEC: exec_valid=1 for exactly this cycle; pc <= pc+1; -> FETCH if run=1, else IDLE.
REQ-027 pc arithmetic SHALL be 4-bit modulo: 4'hF+1 = 4'h0, no flag.
REQ-028 Latency SHALL be 5 cycles per ALU instruction (FETCH..EXEC), 3 cycles per jump.
REQ-029 opcode and operando SHALL hold their values between EXEC pulses.
REQ-030 run deasserted mid-instruction SHALL NOT abort it; run is sampled only in IDLE, at EXEC, and at jump DECODE.
REQ-031 HALT: halted=1; exits to IDLE only when run=0; pc is preserved.
REQ-032 JZ SHALL sample acc_zero in the DECODE cycle only.

Reset
REQ-033 reset=1 at any clock edge SHALL force IDLE, pc=0, ir=0, opcode=0, operando=0, exec_valid=0, halted=0, overriding all other inputs, including mid-instruction.
REQ-034 After reset release with run=1, the first FETCH SHALL occur in the following cycle at address 0.

Structure
REQ-035 State encoding and the default opcode constants (HALT/JMP/JZ) SHALL reside in a shared package used by busca_decod and ucontrol.
REQ-036 The PC (4-bit register with load, increment and clear) SHALL be a sub-module named contador_pc; the remaining logic stays in busca_decod.

Verification
REQ-037 Reset then run=1 with mem[0]=8'h15, mem[5]=8'h2A -> exec_valid pulse in cycle 5 with opcode=1, operando=8'h2A, and pc=1 afterwards.
REQ-038 mem[0]=8'hE9 (JMP 9), mem[9]=8'hF0 -> pc=9 after 3 cycles, then halted=1 and no exec_valid.
REQ-039 JZ: mem[0]=8'hD7 with acc_zero=1 -> pc=7; repeated with acc_zero=0 -> pc=1.
REQ-040 pc=4'hF holding an ALU instruction -> after EXEC, pc=0 and the next FETCH is at address 0.
REQ-041 run dropped during FETCH_WAIT -> the instruction completes with one exec_valid, then IDLE with pc advanced; raising run again resumes at that pc.
REQ-042 reset asserted in OPER_WAIT -> next cycle IDLE, all outputs 0, no exec_valid pulse.
